// File: rtl/ycbcr444_rgb888_pkg.sv
// Shared colour-space-conversion constants and the output saturation helper,
// used by both the forward and the inverse YCbCr converters.
package ycbcr_pkg;

  localparam int CSC_W   = 18;
  localparam int CSC_LAT = 3;

  localparam logic signed [CSC_W-1:0] K_RCR = 18'sd359;
  localparam logic signed [CSC_W-1:0] K_GCB = 18'sd88;
  localparam logic signed [CSC_W-1:0] K_GCR = 18'sd183;
  localparam logic signed [CSC_W-1:0] K_BCB = 18'sd454;
  localparam logic        [7:0]       C_OFS = 8'd128;
  localparam logic signed [CSC_W-1:0] RND   = 18'sd128;

  // Drop the 8 fraction bits (floor) and clamp the integer part to 0..255.
  function automatic logic [7:0] sat_u8(input logic signed [CSC_W-1:0] i_sum);
    logic signed [CSC_W-1:0] w_shr;
    logic [7:0]              w_res;
    w_shr = i_sum >>> 8;
    if (w_shr < 18'sd0) begin
      w_res = 8'd0;
    end else if (w_shr > 18'sd255) begin
      w_res = 8'd255;
    end else begin
      w_res = w_shr[7:0];
    end
    return w_res;
  endfunction

endpackage

// File: rtl/ycbcr444_rgb888_if.sv
// Pixel stream bundle: per_* is the YCbCr side entering the converter,
// post_* is the RGB side leaving it.
interface ycbcr444_rgb888_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          per_frame_vsync;
  logic          per_frame_href;
  logic          per_frame_clken;
  logic [7:0]    per_img_Y;
  logic [7:0]    per_img_Cb;
  logic [7:0]    per_img_Cr;
  logic [XW-1:0] per_setx;
  logic [YW-1:0] per_sety;
  logic          post_frame_vsync;
  logic          post_frame_href;
  logic          post_frame_clken;
  logic [XW-1:0] post_setx;
  logic [YW-1:0] post_sety;
  logic [7:0]    post_img_red;
  logic [7:0]    post_img_green;
  logic [7:0]    post_img_blue;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken,
    output per_img_Y, per_img_Cb, per_img_Cr, per_setx, per_sety,
    input  post_frame_vsync, post_frame_href, post_frame_clken,
    input  post_setx, post_sety, post_img_red, post_img_green, post_img_blue
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken,
    input  per_img_Y, per_img_Cb, per_img_Cr, per_setx, per_sety,
    output post_frame_vsync, post_frame_href, post_frame_clken,
    output post_setx, post_sety, post_img_red, post_img_green, post_img_blue
  );
endinterface

// File: rtl/ycbcr444_rgb888_sync_delay.sv
// Fixed-depth shift register with asynchronous clear; keeps sync and
// coordinate bits aligned with the arithmetic pipeline.
module sync_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  // Shift one stage per clock; reset flushes every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= {WIDTH{1'b0}};
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/ycbcr444_rgb888.sv
// Three-stage YCbCr 4:4:4 -> RGB888 converter: multiply, sum with rounding,
// then shift and saturate. Sync/coordinates ride a matching delay line.
module ycbcr444_rgb888
  import ycbcr_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
) (
  input logic               clk,
  input logic               rst_n,
  ycbcr444_rgb888_if.slave  bus
);

  localparam int SW = 3 + XW + YW;

  logic signed [CSC_W-1:0] w_cb;
  logic signed [CSC_W-1:0] w_cr;
  logic signed [CSC_W-1:0] r_y256, r_rcr, r_gcb, r_gcr, r_bcb;
  logic signed [CSC_W-1:0] r_sum_r, r_sum_g, r_sum_b;
  logic [7:0]              r_red, r_green, r_blue;
  logic [SW-1:0]           w_sync_in;
  logic [SW-1:0]           w_sync_out;

  // Chroma offset removal; results span -128..127 held at full datapath width.
  assign w_cb = $signed({10'b0, bus.per_img_Cb}) - $signed({10'b0, C_OFS});
  assign w_cr = $signed({10'b0, bus.per_img_Cr}) - $signed({10'b0, C_OFS});

  // Stage 1: scaled luma and the four chroma products.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y256 <= 18'sd0;
      r_rcr  <= 18'sd0;
      r_gcb  <= 18'sd0;
      r_gcr  <= 18'sd0;
      r_bcb  <= 18'sd0;
    end else begin
      r_y256 <= $signed({2'b00, bus.per_img_Y, 8'h00});
      r_rcr  <= K_RCR * w_cr;
      r_gcb  <= K_GCB * w_cb;
      r_gcr  <= K_GCR * w_cr;
      r_bcb  <= K_BCB * w_cb;
    end
  end

  // Stage 2: per-channel sums including the round-half-up term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_r <= 18'sd0;
      r_sum_g <= 18'sd0;
      r_sum_b <= 18'sd0;
    end else begin
      r_sum_r <= r_y256 + r_rcr + RND;
      r_sum_g <= r_y256 - r_gcb - r_gcr + RND;
      r_sum_b <= r_y256 + r_bcb + RND;
    end
  end

  // Stage 3: shift out the fraction and clamp into the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_red   <= 8'd0;
      r_green <= 8'd0;
      r_blue  <= 8'd0;
    end else begin
      r_red   <= sat_u8(r_sum_r);
      r_green <= sat_u8(r_sum_g);
      r_blue  <= sat_u8(r_sum_b);
    end
  end

  assign w_sync_in = {bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken,
                      bus.per_setx, bus.per_sety};

  sync_delay #(
    .WIDTH (SW),
    .DEPTH (CSC_LAT)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (w_sync_in),
    .o_q   (w_sync_out)
  );

  assign {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken,
          bus.post_setx, bus.post_sety} = w_sync_out;
  assign bus.post_img_red   = r_red;
  assign bus.post_img_green = r_green;
  assign bus.post_img_blue  = r_blue;

endmodule

// File: tb/tb_ycbcr444_rgb888.sv
// Directed bench for ycbcr444_rgb888: hand-computed colour vectors, a framed
// stream checked against an integer model, and asynchronous mid-stream reset.
module tb_ycbcr444_rgb888;

  localparam int XW = 11;
  localparam int YW = 10;

  typedef struct {
    logic          vs, hr, ce, flush;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    yy, cb, cr;
  } pix_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  pix_t hist[$];

  ycbcr444_rgb888_if #(.XW(XW), .YW(YW)) bus();

  ycbcr444_rgb888 #(.XW(XW), .YW(YW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] clamp8(input int v);
    if (v < 0) return 8'd0;
    else if (v > 255) return 8'd255;
    else return v[7:0];
  endfunction

  // Integer reference of the conversion equations.
  function automatic logic [23:0] ref_rgb(input logic [7:0] y, input logic [7:0] cb,
                                          input logic [7:0] cr);
    int cbs, crs, r, g, b;
    cbs = int'(cb) - 128;
    crs = int'(cr) - 128;
    r = (256 * int'(y) + 359 * crs + 128) >>> 8;
    g = (256 * int'(y) - 88 * cbs - 183 * crs + 128) >>> 8;
    b = (256 * int'(y) + 454 * cbs + 128) >>> 8;
    return {clamp8(r), clamp8(g), clamp8(b)};
  endfunction

  function automatic pix_t mk(input logic vs, input logic hr, input logic ce,
                              input logic [XW-1:0] x, input logic [YW-1:0] y,
                              input logic [7:0] yy, input logic [7:0] cb,
                              input logic [7:0] cr);
    pix_t p;
    p.vs = vs; p.hr = hr; p.ce = ce; p.flush = 1'b0;
    p.x = x; p.y = y; p.yy = yy; p.cb = cb; p.cr = cr;
    return p;
  endfunction

  function automatic logic [23:0] obs_sync();
    return {bus.post_frame_vsync, bus.post_frame_href, bus.post_frame_clken,
            bus.post_setx, bus.post_sety};
  endfunction

  function automatic logic [23:0] obs_rgb();
    return {bus.post_img_red, bus.post_img_green, bus.post_img_blue};
  endfunction

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input pix_t p);
    bus.per_frame_vsync = p.vs;
    bus.per_frame_href  = p.hr;
    bus.per_frame_clken = p.ce;
    bus.per_setx        = p.x;
    bus.per_sety        = p.y;
    bus.per_img_Y       = p.yy;
    bus.per_img_Cb      = p.cb;
    bus.per_img_Cr      = p.cr;
  endtask

  // One clock: present a new input, then compare outputs with the input of three clocks ago.
  task automatic drive(input pix_t p);
    pix_t e;
    @(posedge clk);
    #1;
    apply(p);
    hist.push_back(p);
    e = hist[hist.size()-4];
    check("sync_delay3", obs_sync(), {e.vs, e.hr, e.ce, e.x, e.y});
    if (e.ce || e.flush)
      check("rgb_model", obs_rgb(), e.flush ? 24'd0 : ref_rgb(e.yy, e.cb, e.cr));
    if (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic directed(input string tag, input logic [7:0] yy, input logic [7:0] cb,
                          input logic [7:0] cr, input logic [23:0] exp);
    pix_t bub;
    bub = mk(1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 8'd16, 8'd128, 8'd128);
    drive(mk(1'b0, 1'b1, 1'b1, 11'd1, 10'd1, yy, cb, cr));
    drive(bub);
    drive(bub);
    drive(bub);
    check(tag, obs_rgb(), exp);
  endtask

  initial begin
    pix_t p, z, last;
    logic [XW-1:0] xv;
    logic [YW-1:0] yv;
    z = mk(1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 8'd0, 8'd0, 8'd0);
    z.flush = 1'b1;

    // Reset held with busy inputs: everything must read zero.
    rst_n = 1'b0;
    p = mk(1'b1, 1'b1, 1'b1, 11'd5, 10'd3, 8'd200, 8'd30, 8'd220);
    apply(p);
    repeat (3) @(posedge clk);
    #1;
    check("reset_sync", obs_sync(), 24'd0);
    check("reset_rgb", obs_rgb(), 24'd0);
    #4 rst_n = 1'b1;
    hist.push_back(z);
    hist.push_back(z);
    hist.push_back(p);

    directed("grey",     8'd128, 8'd128, 8'd128, {8'd128, 8'd128, 8'd128});
    directed("sat_high", 8'd255, 8'd128, 8'd255, {8'd255, 8'd164, 8'd255});
    directed("sat_low",  8'd0,   8'd0,   8'd128, {8'd0,   8'd44,  8'd0});
    directed("red",      8'd76,  8'd85,  8'd255, {8'd254, 8'd0,   8'd0});

    // 4x3 frame: vsync one clock ahead, clken every other clock, href gaps between lines.
    drive(mk(1'b1, 1'b0, 1'b0, 11'd0, 10'd0, 8'd0, 8'd128, 8'd128));
    for (int row = 0; row < 3; row++) begin
      for (int c = 0; c < 8; c++) begin
        xv = XW'(c / 2);
        yv = YW'(row);
        drive(mk(1'b0, 1'b1, ((c % 2) == 0), xv, yv, 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))));
      end
      drive(mk(1'b0, 1'b0, 1'b0, xv, yv, 8'd0, 8'd128, 8'd128));
      drive(mk(1'b0, 1'b0, 1'b0, xv, yv, 8'd0, 8'd128, 8'd128));
    end

    // Back-to-back pixels, then an asynchronous reset between clock edges.
    for (int i = 0; i < 6; i++)
      drive(mk(1'b0, 1'b1, 1'b1, XW'(i), 10'd7, 8'(i * 40), 8'(255 - i * 50), 8'(i * 45)));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sync", obs_sync(), 24'd0);
    check("async_rst_rgb", obs_rgb(), 24'd0);
    #2 rst_n = 1'b1;
    last = hist[hist.size()-1];
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    hist.push_back(last);
    for (int i = 0; i < 6; i++)
      drive(mk(1'b0, 1'b1, 1'b1, XW'(i + 8), 10'd8, 8'(250 - i * 30), 8'(i * 51), 8'(200 - i * 33)));
    repeat (3) drive(mk(1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 8'd0, 8'd128, 8'd128));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ycbcr444_rgb888.md
# ycbcr444_rgb888

Pipelined YCbCr 4:4:4 to RGB888 colour-space converter for the video processing chain. It sits downstream of luma/chroma processing (thresholding, skin detection, filtering) and restores RGB888 pixels for the display or frame-buffer path. The datapath uses signed fixed-point arithmetic in three register stages with rounding and saturation. Frame sync, clock enable and pixel coordinates are delayed by the same amount so they stay aligned with the pixel data.

## Interface
- `XW`, default 11: width of the pixel x coordinate.
- `YW`, default 10: width of the pixel y coordinate.
- `clk` in 1: cmos video pixel clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `per_frame_vsync` in 1: input frame vsync.
- `per_frame_href` in 1: input line valid.
- `per_frame_clken` in 1: input pixel enable.
- `per_img_Y` in 8: luma.
- `per_img_Cb` in 8: blue chroma, offset-128.
- `per_img_Cr` in 8: red chroma, offset-128.
- `per_setx` in XW: pixel x coordinate.
- `per_sety` in YW: pixel y coordinate.
- `post_frame_vsync` out 1: vsync, delayed 3 cycles.
- `post_frame_href` out 1: href, delayed 3 cycles.
- `post_frame_clken` out 1: clken, delayed 3 cycles.
- `post_setx` out XW: x coordinate, delayed 3 cycles.
- `post_sety` out YW: y coordinate, delayed 3 cycles.
- `post_img_red` out 8: red result.
- `post_img_green` out 8: green result.
- `post_img_blue` out 8: blue result.

## Operation
- Equations, with cb = Cb−128 and cr = Cr−128 (signed 9-bit, range −128..127):
  - R = (256·Y + 359·cr + 128) >>> 8
  - G = (256·Y − 88·cb − 183·cr + 128) >>> 8
  - B = (256·Y + 454·cb + 128) >>> 8
- `>>>` is an arithmetic right shift (floor). The +128 term gives round-half-up.
- Width rules:
  - All intermediate products and sums are 18-bit signed, with no truncation before the final shift.
  - Worst-case range is −58112..+123066, so 18 bits never overflows.
- Saturation after the shift: negative values become 0; values above 255 become 255; otherwise take the low 8 bits.
- The pipeline is free-running and advances every clock regardless of `per_frame_clken`. Data is meaningful only where `post_frame_clken` is 1.
- No internal state machine beyond the pipeline. Throughput is one pixel per clock.

## Timing
- Stage 1 registers:
  - 256·Y;
  - the products 359·cr, 88·cb, 183·cr and 454·cb;
  - the subtraction of 128 is combinational ahead of the multipliers.
- Stage 2 registers the three 18-bit sums, each including the +128 term.
- Stage 3 registers the shifted and saturated 8-bit RGB values onto the outputs.
- Latency is exactly 3 clocks for all of:
  - input sample to `post_img_*`;
  - every `per_*` sync or coordinate bit to the matching `post_*` bit.
- Back-to-back pixels: a change of input on every clock produces a change of output on every clock, 3 clocks later, with no bubbles.
- Reset:
  - While `rst_n` is 0, every pipeline and delay register clears asynchronously.
  - All outputs read 0, including vsync, href, clken, setx, sety and RGB.
- Reset deasserted mid-frame: the first 3 post-reset cycles output 0 and clken 0 from the flushed stages. Real data follows with no spurious clken pulses.
- Simultaneous vsync/href edges and a pixel pass through unchanged, keeping their relative alignment.

## Structure
- Shared package `ycbcr_pkg` holds:
  - the coefficient constants K_RCR=359, K_GCB=88, K_GCR=183, K_BCB=454;
  - the chroma offset C_OFS=128;
  - the rounding constant RND=128;
  - the pipeline depth CSC_LAT=3;
  - the intermediate width CSC_W=18.
- The forward RGB→YCbCr converter consumes the same package.
- Sub-module `sync_delay` is parameterised by WIDTH and DEPTH.
  - It is a shift register with asynchronous active-low clear.
  - Instantiate it once with WIDTH = 3+XW+YW and DEPTH = CSC_LAT to carry {vsync, href, clken, setx, sety} as one bus.

## Test plan
- Neutral grey: Y=128, Cb=128, Cr=128 → RGB=(128,128,128) exactly 3 clocks later.
- Upper saturation: Y=255, Cb=128, Cr=255 → R=255 (raw 433 clamped), G=164, B=255.
- Lower saturation: Y=0, Cb=0, Cr=128 → R=0, G=44, B=0 (raw −227 clamped).
- Round trip of pure red: Y=76, Cb=85, Cr=255 → RGB=(254,0,0).
- Sync alignment:
  - Stimulus: drive a 4×3 frame, one pixel per clock, with href gaps, clken toggling, and setx/sety incrementing (vsync high one clock before the frame).
  - Required response: every `post_*` sync and coordinate signal equals its input delayed exactly 3 clocks, and RGB matches a reference model at each clken=1 cycle.
- Reset mid-frame: assert `rst_n` low asynchronously between clock edges during streaming → all outputs go to 0 immediately; after release, outputs stay 0 for 3 clocks, then track the input.
